// File: rtl/timer_ctrl_seq.sv
// Avalon-MM master sequencer for the interval-timer slave: programs the period,
// starts/stops the timer, acknowledges timeouts and captures counter snapshots.
module timer_ctrl_seq #(
    parameter int unsigned TICK_W     = 16,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              cfg_err,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        tm_address,
    output logic              tm_chipselect,
    output logic              tm_write_n,
    output logic [15:0]       tm_writedata,
    input  logic [15:0]       tm_readdata,
    input  logic              tm_irq
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CT, SETTLE, RUN, WR_ST, ACK_W, WR_SP,
        SN_WR, SN_RL, SN_RH, SN_CAP
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] load_val;
    logic        cont;
    logic        stop_pend, stop_nxt;
    logic        snap_from_run;
    logic        start_ok;
    logic        accept, reject, snap_launch;

    assign start_ok    = (cfg_period >= 32'(MIN_PERIOD));
    assign busy        = (state != IDLE) && (state != RUN);
    assign running     = (state == RUN);
    assign tick        = (state == WR_ST);
    assign snap_launch = ((state == IDLE) || (state == RUN)) && (state_nxt == SN_WR);

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        reject        = 1'b0;
        tm_chipselect = 1'b0;
        tm_write_n    = 1'b1;
        tm_address    = '0;
        tm_writedata  = '0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    if (start_ok) begin
                        accept    = 1'b1;
                        state_nxt = WR_PL;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (cmd_snap) begin
                    state_nxt = SN_WR;
                end
            end
            WR_PL: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd2;
                tm_writedata  = load_val[15:0];
                state_nxt     = WR_PH;
            end
            WR_PH: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd3;
                tm_writedata  = load_val[31:16];
                state_nxt     = WR_CT;
            end
            WR_CT: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd1;
                tm_writedata  = {12'd0, 1'b0, 1'b1, cont, 1'b1};
                state_nxt     = SETTLE;
            end
            SETTLE: state_nxt = RUN;
            RUN: begin
                // timeout service outranks stop so no tick is lost on a coincident stop
                if (tm_irq) begin
                    state_nxt = WR_ST;
                end else if (stop_pend || cmd_stop) begin
                    state_nxt = WR_SP;
                end else if (cmd_start) begin
                    if (start_ok) begin
                        accept    = 1'b1;
                        state_nxt = WR_PL;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (cmd_snap) begin
                    state_nxt = SN_WR;
                end
            end
            WR_ST: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd0;
                state_nxt     = ACK_W;
            end
            ACK_W: state_nxt = cont ? RUN : IDLE;
            WR_SP: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd1;
                tm_writedata  = 16'h0008;
                state_nxt     = IDLE;
            end
            SN_WR: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd4;
                state_nxt     = SN_RL;
            end
            SN_RL: begin
                tm_chipselect = 1'b1;
                tm_address    = 3'd4;
                state_nxt     = SN_RH;
            end
            SN_RH: begin
                tm_chipselect = 1'b1;
                tm_address    = 3'd5;
                state_nxt     = SN_CAP;
            end
            SN_CAP: state_nxt = snap_from_run ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // a stop seen while busy, or shadowed by an irq in RUN, is held for the next RUN entry
    always_comb begin
        stop_nxt = stop_pend;
        if (cmd_stop && (busy || ((state == RUN) && tm_irq)))
            stop_nxt = 1'b1;
        if ((state == WR_SP) || (state_nxt == IDLE))
            stop_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            load_val      <= '0;
            cont          <= 1'b0;
            stop_pend     <= 1'b0;
            snap_from_run <= 1'b0;
            tick_count    <= '0;
            cfg_err       <= 1'b0;
            snap_value    <= '0;
            snap_valid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            stop_pend  <= stop_nxt;
            snap_valid <= (state == SN_CAP);
            if (accept) begin
                load_val   <= cfg_period - 32'd1;
                cont       <= cfg_continuous;
                tick_count <= '0;
            end else if (state == WR_ST) begin
                tick_count <= tick_count + 1'b1;
            end
            if (reject)
                cfg_err <= 1'b1;
            if (snap_launch)
                snap_from_run <= (state == RUN);
            if (state == SN_RH)
                snap_value[15:0] <= tm_readdata;
            if (state == SN_CAP)
                snap_value[31:16] <= tm_readdata;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_seq.sv
// Directed bench for timer_ctrl_seq with a small registered model of the timer slave.
module tb_timer_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_period;
    logic        cfg_continuous, cmd_start, cmd_stop, cmd_snap;
    logic        busy, running, tick, cfg_err, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  tm_address;
    logic        tm_chipselect, tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata;
    logic        tm_irq;

    logic        w_busy, w_running, w_tick, w_cfg_err, w_snap_valid;
    logic [3:0]  w_tick_count;
    logic [31:0] w_snap_value;
    logic [2:0]  w_tm_address;
    logic        w_tm_chipselect, w_tm_write_n;
    logic [15:0] w_tm_writedata;

    logic        fire;
    logic [31:0] timer_cnt, snap_latch;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    timer_ctrl_seq u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
        .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
        .cfg_err(cfg_err), .snap_value(snap_value), .snap_valid(snap_valid),
        .tm_address(tm_address), .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n),
        .tm_writedata(tm_writedata), .tm_readdata(tm_readdata), .tm_irq(tm_irq)
    );

    // narrow counter copy in lockstep with u_dut, used to reach the wrap quickly
    timer_ctrl_seq #(.TICK_W(4)) u_dut_w4 (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
        .busy(w_busy), .running(w_running), .tick(w_tick), .tick_count(w_tick_count),
        .cfg_err(w_cfg_err), .snap_value(w_snap_value), .snap_valid(w_snap_valid),
        .tm_address(w_tm_address), .tm_chipselect(w_tm_chipselect), .tm_write_n(w_tm_write_n),
        .tm_writedata(w_tm_writedata), .tm_readdata(tm_readdata), .tm_irq(tm_irq)
    );

    always @(posedge clk) begin
        if (!reset_n) begin
            tm_irq      <= 1'b0;
            tm_readdata <= '0;
            snap_latch  <= '0;
        end else begin
            if (tm_chipselect && !tm_write_n && tm_address == 3'd4)
                snap_latch <= timer_cnt;
            if (tm_chipselect && tm_write_n)
                tm_readdata <= (tm_address == 3'd4) ? snap_latch[15:0] :
                               (tm_address == 3'd5) ? snap_latch[31:16] : 16'h0;
            else
                tm_readdata <= 16'h0;
            tm_irq <= fire | (tm_irq & ~(tm_chipselect && !tm_write_n && tm_address == 3'd0));
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bus_now();
        return {11'd0, tm_chipselect, tm_write_n, tm_address, tm_writedata};
    endfunction

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {11'd0, 1'b1, 1'b0, a, d};
    endfunction

    localparam logic [31:0] BUS_IDLE = {11'd0, 1'b0, 1'b1, 3'd0, 16'd0};

    task automatic start(input logic [31:0] period, input logic cont);
        cfg_period     = period;
        cfg_continuous = cont;
        cmd_start      = 1'b1;
        cyc();
        cmd_start      = 1'b0;
    endtask

    task automatic check_prog(input string tag, input logic [31:0] l, input logic [15:0] ctl);
        check({tag, "_pl"}, bus_now(), wr(3'd2, l[15:0]));
        cyc();
        check({tag, "_ph"}, bus_now(), wr(3'd3, l[31:16]));
        cyc();
        check({tag, "_ct"}, bus_now(), wr(3'd1, ctl));
        cyc();
        check({tag, "_settle"}, {30'd0, busy, tm_chipselect}, 32'h2);
        cyc();
        check({tag, "_run"}, {30'd0, running, busy}, 32'h2);
    endtask

    task automatic run_ticks(input string tag, input int n);
        int seen = 0;
        fire = 1'b1;
        for (int i = 0; i < 400 && seen < n; i++) begin
            cyc();
            if (tick) begin
                seen++;
                check({tag, "_wr0"}, bus_now(), wr(3'd0, 16'h0));
                if (seen == n) fire = 1'b0;
            end
        end
        fire = 1'b0;
        check({tag, "_seen"}, seen, n);
        cyc();
        cyc();
    endtask

    task automatic stop_now(input string tag);
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        check({tag, "_sp"}, bus_now(), wr(3'd1, 16'h0008));
        cyc();
        check({tag, "_idle"}, {30'd0, running, busy}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
        fire = 1'b0; timer_cnt = '0;
        repeat (3) cyc();
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            check("rst_bus", bus_now(), BUS_IDLE);
            check("rst_flags", {27'd0, busy, running, tick, cfg_err, snap_valid}, 32'h0);
            check("rst_vals", tick_count | snap_value, 32'h0);
        end

        // rejected start below MIN_PERIOD
        start(32'd1, 1'b1);
        check("err_flag", cfg_err, 1);
        check("err_bus", bus_now(), BUS_IDLE);
        check("err_busy", busy, 0);

        // continuous, 50000 cycles
        start(32'd50000, 1'b1);
        check("c_cnt0", tick_count, 0);
        check_prog("c", 32'd49999, 16'h0007);
        run_ticks("c", 3);
        check("c_count", tick_count, 3);
        check("c_running", running, 1);
        stop_now("c");

        // one-shot, 100 cycles
        start(32'd100, 1'b0);
        check("os_cnt0", tick_count, 0);
        check_prog("os", 32'd99, 16'h0005);
        run_ticks("os", 1);
        check("os_state", {30'd0, running, busy}, 32'h0);
        check("os_count", tick_count, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("os_quiet", bus_now(), BUS_IDLE);
        end

        // smallest accepted period
        start(32'd2, 1'b1);
        check_prog("min", 32'd1, 16'h0007);
        check("min_err_sticky", cfg_err, 1);
        stop_now("min");

        // snapshot in RUN
        timer_cnt = 32'h0001_0ABC;
        start(32'h0001_2345, 1'b1);
        check_prog("sn", 32'h0001_2344, 16'h0007);
        cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        check("sn_wr", bus_now() & 32'h1F_0000, 32'h10_0000 | 32'h4_0000);
        cyc();
        check("sn_rl", bus_now() & 32'h1F_0000, 32'h18_0000 | 32'h4_0000);
        cyc();
        check("sn_rh", bus_now() & 32'h1F_0000, 32'h18_0000 | 32'h5_0000);
        cyc();
        check("sn_cap", {30'd0, busy, snap_valid}, 32'h2);
        cyc();
        check("sn_valid", {30'd0, snap_valid, running}, 32'h3);
        check("sn_value", snap_value, 32'h0001_0ABC);
        cyc();
        check("sn_pulse", {30'd0, snap_valid, running}, 32'h1);

        // irq raised mid-snapshot is serviced afterwards
        cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        fire = 1'b1;
        cyc();
        fire = 1'b0;
        cyc();
        cyc();
        cyc();
        check("sni_back", {30'd0, snap_valid, running}, 32'h3);
        cyc();
        check("sni_tick", {31'd0, tick}, 32'h1);
        check("sni_wr0", bus_now(), wr(3'd0, 16'h0));
        cyc();
        cyc();
        check("sni_count", tick_count, 1);
        check("sni_run", running, 1);

        // restart from RUN, stop arriving during WR_PH
        cfg_period = 32'h0001_2345;
        cfg_continuous = 1'b1;
        cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        check("ps_pl", bus_now(), wr(3'd2, 16'h2344));
        check("ps_cnt0", tick_count, 0);
        cyc();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        check("ps_ct", bus_now(), wr(3'd1, 16'h0007));
        cyc();
        check("ps_settle", {30'd0, busy, tm_chipselect}, 32'h2);
        cyc();
        cyc();
        check("ps_sp", bus_now(), wr(3'd1, 16'h0008));
        cyc();
        check("ps_idle", {30'd0, running, busy}, 32'h0);

        // irq coincident with cmd_stop in RUN
        start(32'h0001_2345, 1'b1);
        check_prog("is", 32'h0001_2344, 16'h0007);
        fire = 1'b1;
        cyc();
        fire = 1'b0;
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        check("is_tick", {31'd0, tick}, 32'h1);
        check("is_wr0", bus_now(), wr(3'd0, 16'h0));
        cyc();
        cyc();
        cyc();
        check("is_sp", bus_now(), wr(3'd1, 16'h0008));
        cyc();
        check("is_idle", {30'd0, running, busy}, 32'h0);

        // tick_count wrap (4-bit copy)
        start(32'h0001_2345, 1'b1);
        check_prog("wr", 32'h0001_2344, 16'h0007);
        run_ticks("wr15", 15);
        check("wr_w4_max", w_tick_count, 4'hF);
        check("wr_16_15", tick_count, 15);
        run_ticks("wr16", 1);
        check("wr_w4_zero", w_tick_count, 4'h0);
        check("wr_16_16", tick_count, 16);
        stop_now("wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
